// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue
// Write-side initiator for the 32x32 register file. Buffers writeback
// requests from the ALU path and the load path in an in-order FIFO and
// drains one write per cycle onto the register-file write port. Also
// publishes a scoreboard of registers that still have a write in flight.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   aluValid/aluReady   ALU writeback handshake (aluReg, aluData)
//   memValid/memReady   load writeback handshake (memReg, memData)
//   regWrite            register-file write enable (registered pulse)
//   writeReg/writeData  register-file write address/data (registered)
//   pending             bit i set while a write to register i is in flight
//   empty               nothing queued and no write on the output stage
module reg_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        aluValid,
  input  logic [4:0]  aluReg,
  input  logic [31:0] aluData,
  output logic        aluReady,
  input  logic        memValid,
  input  logic [4:0]  memReg,
  input  logic [31:0] memData,
  output logic        memReady,
  output logic        regWrite,
  output logic [4:0]  writeReg,
  output logic [31:0] writeData,
  output logic [31:0] pending,
  output logic        empty
);

  logic [4:0]    fifoReg  [DEPTH];
  logic [31:0]   fifoData [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] aluSlot;
  logic [AW:0]   count;
  logic [AW:0]   free;
  logic [1:0]    pushCount;
  logic          memPush;
  logic          aluPush;
  logic          pop;
  logic [31:0]   pendingComb;

  // Free space comes from the registered count only, so a pop in the same
  // cycle never creates room for an extra push.
  assign free = (AW+1)'(DEPTH) - count;

  // The load path gets the last free slot; the ALU needs two slots free
  // whenever a load is competing in the same cycle.
  assign memReady = (free != '0);
  assign aluReady = (free >= (AW+1)'(2)) || ((free != '0) && !memValid);

  // Writes to register 0 complete the handshake but are dropped here.
  assign memPush   = memValid && memReady && (memReg != 5'd0);
  assign aluPush   = aluValid && aluReady && (aluReg != 5'd0);
  assign pushCount = {1'b0, memPush} + {1'b0, aluPush};
  assign pop       = (count != '0);

  // On a dual accept the load entry goes first, so the ALU entry lands one
  // slot after it.
  assign aluSlot = memPush ? tail + AW'(1) : tail;

  // Entry storage carries no reset; validity is tracked by head/count.
  always_ff @(posedge clk) begin
    if (memPush) begin
      fifoReg[tail]  <= memReg;
      fifoData[tail] <= memData;
    end
    if (aluPush) begin
      fifoReg[aluSlot]  <= aluReg;
      fifoData[aluSlot] <= aluData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      regWrite  <= 1'b0;
      writeReg  <= 5'd0;
      writeData <= 32'd0;
    end else begin
      tail     <= tail + AW'(pushCount);
      count    <= count + (AW+1)'(pushCount) - (AW+1)'(pop);
      regWrite <= pop;
      if (pop) begin
        head      <= head + AW'(1);
        writeReg  <= fifoReg[head];
        writeData <= fifoData[head];
      end
    end
  end

  // Scoreboard: every live FIFO entry (the count entries starting at head)
  // plus the write currently presented to the register file.
  always_comb begin
    pendingComb = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((AW+1)'(i) < count) begin
        pendingComb[fifoReg[head + AW'(i)]] = 1'b1;
      end
    end
    if (regWrite) begin
      pendingComb[writeReg] = 1'b1;
    end
    pendingComb[0] = 1'b0;
  end

  assign pending = pendingComb;
  assign empty   = (count == '0) && !regWrite;

endmodule
